// File: rtl/key_schedule.sv
// RC4 key-scheduling stage: fills the S RAM with the identity permutation,
// then swaps entries under control of the latched secret key.
module key_schedule #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             s_read_data,
  output logic [7:0]             s_address,
  output logic                   s_write,
  output logic [7:0]             s_write_data,
  output logic                   finish
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    READ_I  = 4'd2,
    WAIT_I  = 4'd3,
    GET_I   = 4'd4,
    READ_J  = 4'd5,
    WAIT_J  = 4'd6,
    GET_J   = 4'd7,
    WRITE_I = 4'd8,
    WRITE_J = 4'd9,
    DONE    = 4'd10
  } state_t;

  state_t                 state, state_nxt;
  logic [7:0]             i, i_nxt;
  logic [7:0]             j, j_nxt;
  logic [7:0]             si, si_nxt;
  logic [7:0]             sj, sj_nxt;
  logic [8*KEY_BYTES-1:0] key_q, key_nxt;

  logic [7:0] address_nxt;
  logic       write_nxt;
  logic [7:0] write_data_nxt;
  logic       finish_nxt;

  // Key byte (idx mod KEY_BYTES); byte 0 sits in the most significant position.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                          input logic [7:0]             idx);
    logic [31:0] sel;
    sel      = 32'(idx) % 32'(KEY_BYTES);
    key_byte = 8'd0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      key_byte = (sel == 32'(b)) ? key[8*(KEY_BYTES-1-b) +: 8] : key_byte;
    end
  endfunction

  // Next-state and datapath register updates.
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    si_nxt    = si;
    sj_nxt    = sj;
    key_nxt   = key_q;
    case (state)
      IDLE: begin
        if (start) begin
          key_nxt   = secret_key;
          i_nxt     = 8'd0;
          j_nxt     = 8'd0;
          state_nxt = INIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      INIT: begin
        i_nxt = i + 8'd1;
        if (i == 8'd255) begin
          state_nxt = READ_I;
        end else begin
          state_nxt = INIT;
        end
      end
      READ_I: state_nxt = WAIT_I;
      WAIT_I: state_nxt = GET_I;
      GET_I: begin
        si_nxt    = s_read_data;
        j_nxt     = j + s_read_data + key_byte(key_q, i);
        state_nxt = READ_J;
      end
      READ_J: state_nxt = WAIT_J;
      WAIT_J: state_nxt = GET_J;
      GET_J: begin
        sj_nxt    = s_read_data;
        state_nxt = WRITE_I;
      end
      WRITE_I: state_nxt = WRITE_J;
      WRITE_J: begin
        i_nxt = i + 8'd1;
        if (i == 8'd255) begin
          state_nxt = DONE;
        end else begin
          state_nxt = READ_I;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    address_nxt    = 8'd0;
    write_nxt      = 1'b0;
    write_data_nxt = 8'd0;
    finish_nxt     = 1'b0;
    case (state_nxt)
      IDLE: begin
        address_nxt = 8'd0;
      end
      INIT: begin
        address_nxt    = i_nxt;
        write_data_nxt = i_nxt;
        write_nxt      = 1'b1;
      end
      READ_I, WAIT_I, GET_I: begin
        address_nxt = i_nxt;
      end
      READ_J, WAIT_J, GET_J: begin
        address_nxt = j_nxt;
      end
      WRITE_I: begin
        address_nxt    = i_nxt;
        write_data_nxt = sj_nxt;
        write_nxt      = 1'b1;
      end
      WRITE_J: begin
        address_nxt    = j_nxt;
        write_data_nxt = si_nxt;
        write_nxt      = 1'b1;
      end
      DONE: begin
        finish_nxt = 1'b1;
      end
      default: begin
        address_nxt = 8'd0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      i            <= 8'd0;
      j            <= 8'd0;
      si           <= 8'd0;
      sj           <= 8'd0;
      key_q        <= '0;
      s_address    <= 8'd0;
      s_write      <= 1'b0;
      s_write_data <= 8'd0;
      finish       <= 1'b0;
    end else begin
      state        <= state_nxt;
      i            <= i_nxt;
      j            <= j_nxt;
      si           <= si_nxt;
      sj           <= sj_nxt;
      key_q        <= key_nxt;
      s_address    <= address_nxt;
      s_write      <= write_nxt;
      s_write_data <= write_data_nxt;
      finish       <= finish_nxt;
    end
  end

endmodule
